// File: rtl/inst_fetch_if.sv
// Instruction-bus read channel: single outstanding request, one-cycle read-data strobe.
interface inst_fetch_if;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;

  modport master (output ibus_req, ibus_addr, input ibus_rvalid, ibus_rdata);
  modport slave  (input ibus_req, ibus_addr, output ibus_rvalid, ibus_rdata);
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: one outstanding ibus read, a one-entry hold buffer
// for decode stalls, and a discard state that absorbs flushed responses.
module inst_fetch #(
  parameter int unsigned EXC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [31:0]      pc,
  input  logic [EXC_W-1:0] excp_in,
  input  logic             stall,
  input  logic             flush,
  inst_fetch_if.master     ibus,
  output logic             fetch_stall,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_inst,
  output logic [EXC_W-1:0] id_excp
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [31:0]      addr_q;
  logic [31:0]      hold_pc, hold_inst;
  logic [EXC_W-1:0] hold_excp;

  logic             accept;
  logic             load_addr;
  logic             res_valid;
  logic             to_hold;
  logic [31:0]      res_pc, res_inst;
  logic [EXC_W-1:0] res_excp;

  assign accept         = (state == S_IDLE) && i_en && !flush;
  assign fetch_stall    = (state != S_IDLE);
  assign ibus.ibus_req  = (state == S_WAIT) || (state == S_DISCARD);
  assign ibus.ibus_addr = addr_q;

  // res_valid routes a result into IF/ID, to_hold into the buffer; never both.
  always_comb begin
    state_d   = state;
    load_addr = 1'b0;
    res_valid = 1'b0;
    to_hold   = 1'b0;
    res_pc    = '0;
    res_inst  = '0;
    res_excp  = '0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (excp_in == '0) begin
            load_addr = 1'b1;
            state_d   = S_WAIT;
          end else begin
            res_pc   = pc;
            res_excp = excp_in;
            if (stall) begin
              to_hold = 1'b1;
              state_d = S_HOLD;
            end else begin
              res_valid = 1'b1;
            end
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = ibus.ibus_rvalid ? S_IDLE : S_DISCARD;
        end else if (ibus.ibus_rvalid) begin
          res_pc   = addr_q;
          res_inst = ibus.ibus_rdata;
          if (stall) begin
            to_hold = 1'b1;
            state_d = S_HOLD;
          end else begin
            res_valid = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (!stall) begin
          res_pc    = hold_pc;
          res_inst  = hold_inst;
          res_excp  = hold_excp;
          res_valid = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (ibus.ibus_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      addr_q <= '0;
    end else begin
      state <= state_d;
      if (load_addr) addr_q <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_pc   <= '0;
      hold_inst <= '0;
      hold_excp <= '0;
    end else if (to_hold) begin
      hold_pc   <= res_pc;
      hold_inst <= res_inst;
      hold_excp <= res_excp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
      id_excp  <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_valid <= res_valid;
      if (res_valid) begin
        id_pc   <= res_pc;
        id_inst <= res_inst;
        id_excp <= res_excp;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with inline checks plus a scoreboard
// popped whenever decode takes an instruction out of IF/ID.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic [31:0] pc;
  logic [31:0] excp_in;
  logic        stall;
  logic        flush;
  logic        fetch_stall;
  logic        id_valid;
  logic [31:0] id_pc, id_inst, id_excp;

  inst_fetch_if bus ();

  inst_fetch #(.EXC_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .pc         (pc),
    .excp_in    (excp_in),
    .stall      (stall),
    .flush      (flush),
    .ibus       (bus.master),
    .fetch_stall(fetch_stall),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_excp    (id_excp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] excp;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Decode takes the IF/ID word on any edge where it is valid and neither stalled nor flushed.
  always @(negedge clk) begin
    if (rst === 1'b1 && id_valid === 1'b1 && stall === 1'b0 && flush === 1'b0) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL sb_unexpected got pc=%h inst=%h excp=%h", id_pc, id_inst, id_excp);
      end else begin
        mon_e = exp_q.pop_front();
        if ({id_pc, id_inst, id_excp} !== mon_e) begin
          bad = bad + 1;
          $display("FAIL sb_data got pc=%h inst=%h excp=%h exp pc=%h inst=%h excp=%h",
                   id_pc, id_inst, id_excp, mon_e.pc, mon_e.inst, mon_e.excp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_en = 1'b1; pc = 32'hBFC0_0000; excp_in = '0;
    stall = 1'b0; flush = 1'b0; bus.ibus_rvalid = 1'b0; bus.ibus_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({bus.ibus_req, id_valid, fetch_stall} !== 3'b000) begin bad++; $display("FAIL rst_ctl got=%b exp=000", {bus.ibus_req, id_valid, fetch_stall}); end
      total++; if ({bus.ibus_addr, id_pc, id_inst, id_excp} !== 128'd0) begin bad++; $display("FAIL rst_data got addr=%h pc=%h inst=%h excp=%h exp=0", bus.ibus_addr, id_pc, id_inst, id_excp); end
    end
    rst = 1'b1;
    exp_q.push_back('{32'hBFC0_0000, 32'h3C1D_8000, 32'h0});
    tick();
    i_en = 1'b0;
    total++; if (bus.ibus_req !== 1'b1) begin bad++; $display("FAIL launch_req got=%b exp=1", bus.ibus_req); end
    total++; if (bus.ibus_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL launch_addr got=%h exp=bfc00000", bus.ibus_addr); end
    bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h3C1D_8000;
    tick();
    bus.ibus_rvalid = 1'b0;
    total++; if ({id_valid, id_pc, id_inst} !== {1'b1, 32'hBFC0_0000, 32'h3C1D_8000}) begin bad++; $display("FAIL launch_id got v=%b pc=%h inst=%h exp v=1 pc=bfc00000 inst=3c1d8000", id_valid, id_pc, id_inst); end
    total++; if ({bus.ibus_req, fetch_stall} !== 2'b00) begin bad++; $display("FAIL launch_idle got=%b exp=00", {bus.ibus_req, fetch_stall}); end
    tick();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL launch_drain got=%b exp=0", id_valid); end
  endtask

  task automatic test_wait_states();
    pc = 32'hBFC0_0004; i_en = 1'b1;
    exp_q.push_back('{32'hBFC0_0004, 32'h8C02_0010, 32'h0});
    tick();
    i_en = 1'b0; pc = 32'h1111_1110;
    for (int i = 0; i < 4; i++) begin
      total++; if ({fetch_stall, bus.ibus_req} !== 2'b11) begin bad++; $display("FAIL ws_stall[%0d] got=%b exp=11", i, {fetch_stall, bus.ibus_req}); end
      total++; if (bus.ibus_addr !== 32'hBFC0_0004) begin bad++; $display("FAIL ws_addr[%0d] got=%h exp=bfc00004", i, bus.ibus_addr); end
      if (i == 3) begin bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h8C02_0010; end
      tick();
    end
    bus.ibus_rvalid = 1'b0;
    total++; if ({id_valid, fetch_stall} !== 2'b10) begin bad++; $display("FAIL ws_done got=%b exp=10", {id_valid, fetch_stall}); end
    tick();
  endtask

  task automatic test_decode_stall();
    pc = 32'hBFC0_0040; i_en = 1'b1;
    exp_q.push_back('{32'hBFC0_0040, 32'h8C08_0000, 32'h0});
    tick();
    i_en = 1'b0;
    bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h8C08_0000;
    tick();
    bus.ibus_rvalid = 1'b0;
    total++; if ({id_valid, id_inst} !== {1'b1, 32'h8C08_0000}) begin bad++; $display("FAIL ds_first got v=%b inst=%h exp v=1 inst=8c080000", id_valid, id_inst); end
    stall = 1'b1; pc = 32'hBFC0_0044; i_en = 1'b1;
    exp_q.push_back('{32'hBFC0_0044, 32'h2408_0001, 32'h0});
    tick();
    i_en = 1'b0;
    total++; if ({bus.ibus_req, bus.ibus_addr} !== {1'b1, 32'hBFC0_0044}) begin bad++; $display("FAIL ds_req got req=%b addr=%h exp req=1 addr=bfc00044", bus.ibus_req, bus.ibus_addr); end
    bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h2408_0001;
    tick();
    bus.ibus_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if ({fetch_stall, bus.ibus_req} !== 2'b10) begin bad++; $display("FAIL ds_hold[%0d] got=%b exp=10", i, {fetch_stall, bus.ibus_req}); end
      total++; if ({id_valid, id_pc, id_inst} !== {1'b1, 32'hBFC0_0040, 32'h8C08_0000}) begin bad++; $display("FAIL ds_keep[%0d] got v=%b pc=%h inst=%h exp v=1 pc=bfc00040 inst=8c080000", i, id_valid, id_pc, id_inst); end
      if (i == 1) stall = 1'b0;
      tick();
    end
    total++; if ({id_valid, id_inst, fetch_stall} !== {1'b1, 32'h2408_0001, 1'b0}) begin bad++; $display("FAIL ds_release got v=%b inst=%h fs=%b exp v=1 inst=24080001 fs=0", id_valid, id_inst, fetch_stall); end
    tick();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL ds_drain got=%b exp=0", id_valid); end
  endtask

  task automatic test_flush_inflight();
    pc = 32'hBFC0_0010; i_en = 1'b1;
    tick();
    i_en = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0; pc = 32'hBFC0_0380; i_en = 1'b1;
    total++; if ({bus.ibus_req, fetch_stall, id_valid} !== 3'b110) begin bad++; $display("FAIL fl_discard got=%b exp=110", {bus.ibus_req, fetch_stall, id_valid}); end
    tick();
    total++; if (bus.ibus_addr !== 32'hBFC0_0010) begin bad++; $display("FAIL fl_addr_stable got=%h exp=bfc00010", bus.ibus_addr); end
    bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'hDEAD_BEEF;
    exp_q.push_back('{32'hBFC0_0380, 32'h3C08_8000, 32'h0});
    tick();
    bus.ibus_rvalid = 1'b0;
    total++; if ({bus.ibus_req, fetch_stall, id_valid} !== 3'b000) begin bad++; $display("FAIL fl_drop got=%b exp=000", {bus.ibus_req, fetch_stall, id_valid}); end
    tick();
    i_en = 1'b0;
    total++; if ({bus.ibus_req, bus.ibus_addr} !== {1'b1, 32'hBFC0_0380}) begin bad++; $display("FAIL fl_newpc got req=%b addr=%h exp req=1 addr=bfc00380", bus.ibus_req, bus.ibus_addr); end
    bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h3C08_8000;
    tick();
    bus.ibus_rvalid = 1'b0;
    total++; if ({id_valid, id_pc} !== {1'b1, 32'hBFC0_0380}) begin bad++; $display("FAIL fl_newid got v=%b pc=%h exp v=1 pc=bfc00380", id_valid, id_pc); end
    tick();
  endtask

  task automatic test_exception();
    pc = 32'hBFC0_0002; excp_in = 32'h0000_0010; i_en = 1'b1;
    exp_q.push_back('{32'hBFC0_0002, 32'h0, 32'h0000_0010});
    tick();
    i_en = 1'b0; excp_in = '0;
    total++; if ({bus.ibus_req, fetch_stall} !== 2'b00) begin bad++; $display("FAIL ex_nobus got=%b exp=00", {bus.ibus_req, fetch_stall}); end
    total++; if ({id_valid, id_pc, id_inst, id_excp} !== {1'b1, 32'hBFC0_0002, 32'h0, 32'h0000_0010}) begin bad++; $display("FAIL ex_id got v=%b pc=%h inst=%h excp=%h", id_valid, id_pc, id_inst, id_excp); end
    tick();
    stall = 1'b1; pc = 32'hBFC0_0006; excp_in = 32'h0000_0020; i_en = 1'b1;
    exp_q.push_back('{32'hBFC0_0006, 32'h0, 32'h0000_0020});
    tick();
    i_en = 1'b0; excp_in = '0;
    total++; if ({fetch_stall, bus.ibus_req, id_valid} !== 3'b100) begin bad++; $display("FAIL ex_hold got=%b exp=100", {fetch_stall, bus.ibus_req, id_valid}); end
    stall = 1'b0;
    tick();
    total++; if ({id_valid, id_pc, id_excp, fetch_stall} !== {1'b1, 32'hBFC0_0006, 32'h0000_0020, 1'b0}) begin bad++; $display("FAIL ex_release got v=%b pc=%h excp=%h fs=%b", id_valid, id_pc, id_excp, fetch_stall); end
    tick();
  endtask

  task automatic test_simultaneous();
    pc = 32'hBFC0_0020; i_en = 1'b1;
    tick();
    i_en = 1'b0;
    flush = 1'b1; bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h0BAD_0BAD;
    tick();
    flush = 1'b0; bus.ibus_rvalid = 1'b0;
    total++; if ({bus.ibus_req, fetch_stall, id_valid} !== 3'b000) begin bad++; $display("FAIL sim_drop got=%b exp=000", {bus.ibus_req, fetch_stall, id_valid}); end
    bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h5555_AAAA;
    tick();
    bus.ibus_rvalid = 1'b0;
    total++; if ({bus.ibus_req, fetch_stall, id_valid} !== 3'b000) begin bad++; $display("FAIL sim_stray_rvalid got=%b exp=000", {bus.ibus_req, fetch_stall, id_valid}); end
    pc = 32'hBFC0_0024; i_en = 1'b1;
    tick();
    i_en = 1'b0; stall = 1'b1;
    bus.ibus_rvalid = 1'b1; bus.ibus_rdata = 32'h7777_0000;
    tick();
    bus.ibus_rvalid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    total++; if ({fetch_stall, id_valid} !== 2'b00) begin bad++; $display("FAIL sim_holdflush got=%b exp=00", {fetch_stall, id_valid}); end
    tick();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL sim_holdflush_after got=%b exp=0", id_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int k = 0; k < 4; k++) begin
      a = 32'hBFC0_0100 + 32'(k * 4);
      pc = a; i_en = 1'b1;
      exp_q.push_back('{a, a ^ 32'h1234_5678, 32'h0});
      tick();
      total++; if ({bus.ibus_req, bus.ibus_addr} !== {1'b1, a}) begin bad++; $display("FAIL b2b_req[%0d] got req=%b addr=%h exp req=1 addr=%h", k, bus.ibus_req, bus.ibus_addr, a); end
      bus.ibus_rvalid = 1'b1; bus.ibus_rdata = a ^ 32'h1234_5678;
      tick();
      bus.ibus_rvalid = 1'b0;
      total++; if ({id_valid, fetch_stall} !== 2'b10) begin bad++; $display("FAIL b2b_id[%0d] got=%b exp=10", k, {id_valid, fetch_stall}); end
    end
    i_en = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wait_states();
    test_decode_stall();
    test_flush_inflight();
    test_exception();
    test_simultaneous();
    test_back_to_back();
    repeat (2) tick();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
